// File: rtl/regs_wb_arbiter_if.sv
// regs_wb_arbiter_if: writeback requester bundle (valid/addr/data in, one-hot ready out)
interface regs_wb_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [5*NUM_REQ-1:0]  req_addr;
  logic [32*NUM_REQ-1:0] req_data;
  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: register file write port arbiter with pending-write scoreboard.
// Define WB_ARB_RR_EN for round-robin grants; otherwise lowest index wins.
module regs_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  regs_wb_arbiter_if.slave  bus,
  input  logic              rsv_valid,
  input  logic [4:0]        rsv_addr,
  input  logic              flush,
  input  logic [4:0]        R_addr_A,
  input  logic [4:0]        R_addr_B,
  output logic              busy_A,
  output logic              busy_B,
  output logic              L_S,
  output logic [4:0]        Wt_addr,
  output logic [31:0]       Wt_data,
  output logic [IDX_W-1:0]  grant_idx
);
  logic                 any_v;
  logic                 hs;
  int                   sel_i;
  int                   idx_i;
  logic [NUM_REQ-1:0]   valid_sh;
  logic [4:0]           sel_addr;
  logic [31:0]          sel_data;
  logic                 ls_q, ls_d;
  logic [4:0]           wa_q, wa_d;
  logic [31:0]          wd_q, wd_d;
  logic [IDX_W-1:0]     gi_q, gi_d;
  logic [31:0]          sb_q, sb_d;
`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif
  always_comb begin
    any_v = 1'b0;
    sel_i = 0;
    idx_i = 0;
    valid_sh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_ARB_RR_EN
      idx_i = (int'(ptr_q) + k) % NUM_REQ;
`else
      idx_i = k;
`endif
      valid_sh = bus.req_valid >> idx_i;
      if (!any_v && valid_sh[0]) begin
        any_v = 1'b1;
        sel_i = idx_i;
      end
    end
  end
  // reset suppresses the grant so nothing is consumed while rst is high
  assign hs            = any_v && !rst;
  assign bus.req_ready = hs ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel_i) : '0;
  assign sel_addr      = 5'(bus.req_addr >> (5 * sel_i));
  assign sel_data      = 32'(bus.req_data >> (32 * sel_i));
  always_comb begin
    ls_d = hs && (sel_addr != 5'd0);
    wa_d = hs ? sel_addr : wa_q;
    wd_d = hs ? sel_data : wd_q;
    gi_d = hs ? IDX_W'(sel_i) : gi_q;
  end
  // reserve is applied after the write clear so it wins; flush overrides both
  always_comb begin
    sb_d = sb_q;
    if (hs) sb_d[sel_addr] = 1'b0;
    if (rsv_valid) sb_d[rsv_addr] = 1'b1;
    sb_d[0] = 1'b0;
    if (flush) sb_d = '0;
  end
`ifdef WB_ARB_RR_EN
  assign ptr_d = hs ? IDX_W'((sel_i + 1) % NUM_REQ) : ptr_q;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ls_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      gi_q <= '0;
      sb_q <= '0;
    end else begin
      ls_q <= ls_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      gi_q <= gi_d;
      sb_q <= sb_d;
    end
  end
  assign busy_A    = (R_addr_A != 5'd0) && sb_q[R_addr_A];
  assign busy_B    = (R_addr_B != 5'd0) && sb_q[R_addr_B];
  assign L_S       = ls_q;
  assign Wt_addr   = wa_q;
  assign Wt_data   = wd_q;
  assign grant_idx = gi_q;
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter: directed and randomized checks against a behavioural model of regs_wb_arbiter
module tb_regs_wb_arbiter;
  localparam int N = 3;
  localparam int IW = 2;
  logic clk, rst, rsv_valid, flush, busy_A, busy_B, L_S;
  logic [4:0] rsv_addr, R_addr_A, R_addr_B, Wt_addr;
  logic [31:0] Wt_data;
  logic [IW-1:0] grant_idx;
  int checks = 0;
  int errors = 0;
  bit m_sb [32];
  int m_ptr;
  logic m_ls;
  logic [4:0] m_wa;
  logic [31:0] m_wd;
  logic [IW-1:0] m_gi;
  regs_wb_arbiter_if #(.NUM_REQ(N)) bus ();
  regs_wb_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .flush(flush), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B), .busy_A(busy_A),
    .busy_B(busy_B), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .grant_idx(grant_idx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
    m_ptr = 0;
    m_ls = 1'b0;
    m_wa = '0;
    m_wd = '0;
    m_gi = '0;
  endfunction
  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
`ifdef WB_ARB_RR_EN
      int j = (m_ptr + k) % N;
`else
      int j = k;
`endif
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction
  function automatic bit model_busy(input logic [4:0] a);
    return (a != 0) && m_sb[a];
  endfunction
  task automatic clr();
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    rsv_valid = 1'b0;
    rsv_addr = '0;
    flush = 1'b0;
    R_addr_A = '0;
    R_addr_B = '0;
  endtask
  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_addr[5*i +: 5] = a;
    bus.req_data[32*i +: 32] = d;
  endtask
  // one clock: check combinational outputs, clock, advance model, check registered outputs
  task automatic step();
    int g;
    logic [N-1:0] er;
    logic [4:0] a;
    #1;
    g = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    checks++;
    if (bus.req_ready !== er) begin errors++; $display("FAIL ready got %b exp %b", bus.req_ready, er); end
    checks++;
    if (busy_A !== model_busy(R_addr_A)) begin errors++; $display("FAIL busy_A addr %0d got %b exp %b", R_addr_A, busy_A, model_busy(R_addr_A)); end
    checks++;
    if (busy_B !== model_busy(R_addr_B)) begin errors++; $display("FAIL busy_B addr %0d got %b exp %b", R_addr_B, busy_B, model_busy(R_addr_B)); end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_ls = 1'b0;
      if (g >= 0) begin
        a = bus.req_addr[5*g +: 5];
        m_ls = (a != 0);
        m_wa = a;
        m_wd = bus.req_data[32*g +: 32];
        m_gi = IW'(g);
        m_sb[a] = 1'b0;
        m_ptr = (g + 1) % N;
      end
      if (rsv_valid && rsv_addr != 0) m_sb[rsv_addr] = 1'b1;
      if (flush) for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
    end
    #1;
    checks++;
    if (L_S !== m_ls) begin errors++; $display("FAIL L_S got %b exp %b", L_S, m_ls); end
    checks++;
    if (Wt_addr !== m_wa) begin errors++; $display("FAIL Wt_addr got %0d exp %0d", Wt_addr, m_wa); end
    checks++;
    if (Wt_data !== m_wd) begin errors++; $display("FAIL Wt_data got %h exp %h", Wt_data, m_wd); end
    checks++;
    if (grant_idx !== m_gi) begin errors++; $display("FAIL grant_idx got %0d exp %0d", grant_idx, m_gi); end
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_addr = {5'd3, 5'd2, 5'd1};
    bus.req_data = {32'h3, 32'h2, 32'h1};
    rsv_valid = 1'b1;
    rsv_addr = 5'd1;
    R_addr_A = 5'd1;
    R_addr_B = 5'd2;
    @(posedge clk);
    @(negedge clk);
    step();
    checks++;
    if (L_S !== 1'b0) begin errors++; $display("FAIL reset_L_S got %b exp 0", L_S); end
    checks++;
    if (Wt_addr !== 5'd0) begin errors++; $display("FAIL reset_Wt_addr got %0d exp 0", Wt_addr); end
    checks++;
    if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 000", bus.req_ready); end
    checks++;
    if (busy_A !== 1'b0 || busy_B !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b exp 00", busy_A, busy_B); end
    rst = 1'b0;
    clr();
    step();
  endtask
  task automatic test_single();
    rsv_valid = 1'b1;
    rsv_addr = 5'd5;
    step();
    clr();
    R_addr_A = 5'd5;
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b exp 010", bus.req_ready); end
    checks++;
    if (busy_A !== 1'b1) begin errors++; $display("FAIL single_busy_before got %b exp 1", busy_A); end
    step();
    bus.req_valid = '0;
    #1;
    checks++;
    if (L_S !== 1'b1 || Wt_addr !== 5'd5 || Wt_data !== 32'hDEADBEEF || grant_idx !== 2'd1) begin
      errors++;
      $display("FAIL single_write got ls=%b a=%0d d=%h g=%0d exp ls=1 a=5 d=deadbeef g=1", L_S, Wt_addr, Wt_data, grant_idx);
    end
    checks++;
    if (busy_A !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b exp 0", busy_A); end
    @(negedge clk);
    clr();
  endtask
  task automatic test_contention();
    logic [IW-1:0] exp_g [3];
    rst = 1'b1;
    step();
    rst = 1'b0;
`ifdef WB_ARB_RR_EN
    exp_g = '{2'd0, 2'd1, 2'd2};
`else
    exp_g = '{2'd0, 2'd0, 2'd0};
`endif
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 11), 32'h100 + i);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (grant_idx !== exp_g[c]) begin errors++; $display("FAIL contention_%0d got %0d exp %0d", c, grant_idx, exp_g[c]); end
    end
    clr();
  endtask
  task automatic test_addr0();
    set_req(2, 5'd0, 32'h1234);
    #1;
    checks++;
    if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL addr0_ready got %b exp 100", bus.req_ready); end
    step();
    clr();
    rsv_valid = 1'b1;
    step();
    rsv_valid = 1'b0;
    checks++;
    if (busy_A !== 1'b0) begin errors++; $display("FAIL addr0_busy got %b exp 0", busy_A); end
    set_req(0, 5'd0, 32'h55);
    step();
    checks++;
    if (L_S !== 1'b0 || Wt_data !== 32'h55) begin errors++; $display("FAIL addr0_write got ls=%b d=%h exp ls=0 d=55", L_S, Wt_data); end
    clr();
  endtask
  task automatic test_collision();
    rsv_valid = 1'b1;
    rsv_addr = 5'd7;
    step();
    set_req(0, 5'd7, 32'hCAFE);
    R_addr_B = 5'd7;
    step();
    clr();
    R_addr_A = 5'd7;
    #1;
    checks++;
    if (busy_A !== 1'b1) begin errors++; $display("FAIL collision_busy got %b exp 1", busy_A); end
    checks++;
    if (L_S !== 1'b1 || Wt_addr !== 5'd7) begin errors++; $display("FAIL collision_write got ls=%b a=%0d exp ls=1 a=7", L_S, Wt_addr); end
    @(negedge clk);
  endtask
  task automatic test_flush();
    logic [4:0] regs [4];
    regs = '{5'd3, 5'd4, 5'd9, 5'd10};
    clr();
    rsv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rsv_addr = regs[i];
      step();
    end
    flush = 1'b1;
    rsv_addr = 5'd10;
    step();
    clr();
    for (int i = 0; i < 4; i++) begin
      R_addr_A = regs[i];
      R_addr_B = regs[3 - i];
      #1;
      checks++;
      if (busy_A !== 1'b0 || busy_B !== 1'b0) begin
        errors++;
        $display("FAIL flush_busy r%0d/r%0d got %b%b exp 00", regs[i], regs[3 - i], busy_A, busy_B);
      end
    end
    @(negedge clk);
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.req_addr[5*i +: 5] = 5'($urandom);
        bus.req_data[32*i +: 32] = $urandom;
      end
      rsv_valid = $urandom_range(0, 1) == 1;
      rsv_addr = 5'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      R_addr_A = 5'($urandom);
      R_addr_B = 5'($urandom);
      step();
    end
    rst = 1'b0;
    clr();
  endtask
  initial begin
    model_reset();
    clr();
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_addr0();
    test_collision();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters, e.g. ALU, load unit and multiplier.
- Grants one requester per cycle with a valid/ready handshake.
- Registers the winner onto the register file write interface: write enable L_S, address Wt_addr, data Wt_data.
- Keeps a 31-entry pending-write scoreboard so issue logic can stall on read-after-write hazards for read ports A and B.

Parameters:
- NUM_REQ, 3, number of writeback requesters; legal range 2..8.
- IDX_W, 2, grant index width; must satisfy 2^IDX_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  5*NUM_REQ  destination register; requester i occupies bits [5i+4:5i].
- req_data  input  32*NUM_REQ  write data; requester i occupies bits [32i+31:32i].
- req_ready  output  NUM_REQ  one-hot grant; the transfer completes when valid and ready are both high in the same cycle.
- rsv_valid  input  1  issue logic reserves a destination register, marking it pending.
- rsv_addr  input  5  register to reserve.
- flush  input  1  clears all scoreboard bits at the next edge.
- R_addr_A  input  5  read address A to check.
- R_addr_B  input  5  read address B to check.
- busy_A  output  1  R_addr_A has a pending write.
- busy_B  output  1  R_addr_B has a pending write.
- L_S  output  1  register file write enable, registered.
- Wt_addr  output  5  register file write address, registered.
- Wt_data  output  32  register file write data, registered.
- grant_idx  output  IDX_W  index of the last accepted requester, registered.

Behaviour:
- Reset values:
  - L_S=0, Wt_addr=0, Wt_data=0, grant_idx=0.
  - All scoreboard bits 0; round-robin pointer 0.
  - req_ready=0 while rst=1.
- Grant logic:
  - req_ready is combinational from req_valid and the arbiter state.
  - At most one bit of req_ready is high.
  - req_ready[i] is never high unless req_valid[i] is high.
  - If any req_valid bit is high, exactly one grant is issued that cycle; there is no backpressure from the register file.
- Output stage, one-cycle latency:
  - At the edge after the handshake: Wt_addr/Wt_data take the granted requester's addr/data and grant_idx takes its index.
  - L_S=1 only if the granted address is nonzero.
  - With no grant, L_S=0 and Wt_addr/Wt_data/grant_idx hold their previous values.
- Address 0:
  - A write to register 0 is still granted and consumed (ready=1), but produces L_S=0.
  - Register 0 is never marked busy.
- Scoreboard, one bit per register 1..31:
  - A handshake to address a clears bit a at the next edge.
  - rsv_valid with rsv_addr=a (a≠0) sets bit a at the next edge.
  - Reserve and clear of the same address in one cycle: reserve wins, bit ends at 1.
  - flush clears every bit and overrides a reserve in the same cycle.
  - Grants and writes are unaffected by flush.
- Busy outputs:
  - busy_A = (R_addr_A≠0) & bit[R_addr_A], computed combinationally from the registered bits.
  - busy_B uses R_addr_B the same way.
  - A write accepted in cycle t makes busy drop in cycle t+1, the same cycle L_S is asserted.
- Hold requirement: requesters must hold valid/addr/data until ready; the block does not check this.
- Reset mid-operation: a pending grant is discarded, L_S=0 at the next edge, and the scoreboard is cleared.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined (round-robin):
  - Search starts at the pointer and wraps through index NUM_REQ-1 back to 0.
  - After a grant to g, the pointer becomes (g+1) mod NUM_REQ.
  - With no grant, the pointer holds.
- Undefined (fixed priority):
  - The lowest index with valid=1 is granted.
  - The pointer logic is absent.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs active -> L_S=0, Wt_addr=0, busy_A=busy_B=0, req_ready=0.
- Single write: rsv_valid with addr 5; then req_valid[1]=1, addr=5, data=0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle L_S=1, Wt_addr=5, Wt_data=0xDEADBEEF, grant_idx=1, busy for R_addr_A=5 goes 1 -> 0.
- Contention: req_valid=3'b111 held for 3 grants:
  - With WB_ARB_RR_EN: grants 0, 1, 2 in successive cycles.
  - Without it: grant 0 every cycle.
- Address 0: req_valid[2]=1, addr=0, data=0x1234 -> ready=3'b100, next cycle L_S=0; busy_A with R_addr_A=0 is always 0.
- Reserve/clear collision: bit 7 set; in one cycle rsv_addr=7 and a write to 7 is granted -> busy stays 1 afterwards.
- Flush: reserve regs 3, 4 and 9, then flush together with rsv_addr=10 -> next cycle all busy checks return 0, including 10.
